// File: rtl/gate_net_pkg.sv
// Shared defaults, state encoding and width helper for the gate-network vote accumulator.
// GATE_NET_VOTE_COUNTS_EN (see gate_net_vote_accum) adds the out_counts port.
package gate_net_pkg;

    function automatic int cls_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_NUM_CLASSES = 2;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_CLS_W       = cls_width(DEF_NUM_CLASSES);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

endpackage

// File: rtl/gate_net_argmax.sv
// Combinational argmax over per-class vote counts: lowest index wins, tie flags a shared maximum.
module gate_net_argmax
    import gate_net_pkg::*;
#(
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int CLS_W       = cls_width(NUM_CLASSES)
) (
    input  logic [NUM_CLASSES-1:0][CNT_W-1:0] counts,
    output logic [CLS_W-1:0]                  max_class,
    output logic                              tie
);

    logic [CNT_W-1:0] best;
    logic             seen;

    always_comb begin
        best      = counts[0];
        max_class = '0;
        tie       = 1'b0;
        seen      = 1'b0;
        // Strict compare keeps the lowest index when counts are equal.
        for (int i = 1; i < NUM_CLASSES; i++) begin
            if (counts[i] > best) begin
                best      = counts[i];
                max_class = CLS_W'(i);
            end
        end
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (counts[i] == best) begin
                tie  = tie | seen;
                seen = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gate_net_vote_accum.sv
// Accumulates multi-hot class votes over a frame and presents the argmax decision.
// Define GATE_NET_VOTE_COUNTS_EN to expose the final per-class counts on out_counts.
module gate_net_vote_accum
    import gate_net_pkg::*;
#(
    parameter  int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter  int CNT_W       = DEF_CNT_W,
    localparam int CLS_W       = cls_width(NUM_CLASSES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_CLASSES-1:0] in_bits,
    input  logic [CNT_W-1:0]       frame_len,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CLS_W-1:0]       out_class,
    output logic                   out_tie
`ifdef GATE_NET_VOTE_COUNTS_EN
    ,
    output logic [NUM_CLASSES*CNT_W-1:0] out_counts
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // valid never depends on ready, and out_* hold steady while out_valid waits for out_ready.

    state_e                           state_q, state_d;
    logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]                 samp_q, samp_d;
    logic [CNT_W-1:0]                 len_q, len_d;
    logic [CNT_W-1:0]                 len_eff;
    logic [CLS_W-1:0]                 am_class;
    logic                             am_tie;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            samp_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            samp_q  <= samp_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        samp_d  = samp_q;
        len_d   = len_q;
        // The first sample of a frame uses the live frame_len; zero means a one-sample frame.
        if (samp_q == '0) begin
            len_eff = (frame_len == '0) ? CNT_W'(1) : frame_len;
        end else begin
            len_eff = len_q;
        end
        case (state_q)
            ACCUM: begin
                if (flush) begin
                    cnt_d  = '0;
                    samp_d = '0;
                end else if (in_valid) begin
                    for (int i = 0; i < NUM_CLASSES; i++) begin
                        if (in_bits[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    samp_d = samp_q + 1'b1;
                    len_d  = len_eff;
                    if (samp_d == len_eff) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    cnt_d   = '0;
                    samp_d  = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    gate_net_argmax #(
        .NUM_CLASSES (NUM_CLASSES),
        .CNT_W       (CNT_W),
        .CLS_W       (CLS_W)
    ) u_argmax (
        .counts    (cnt_q),
        .max_class (am_class),
        .tie       (am_tie)
    );

    // Counts are frozen in DONE, so the decision is stable until the handshake.
    assign in_ready  = (state_q == ACCUM) & ~flush;
    assign out_valid = (state_q == DONE);
    assign out_class = out_valid ? am_class : '0;
    assign out_tie   = out_valid & am_tie;

`ifdef GATE_NET_VOTE_COUNTS_EN
    assign out_counts = cnt_q;
`endif

endmodule

// File: tb/tb_gate_net_vote_accum.sv
// Directed bench for gate_net_vote_accum with hand-computed decisions per frame.
module tb_gate_net_vote_accum;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_bits;
    logic [7:0] frame_len;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [0:0] out_class;
    logic       out_tie;
`ifdef GATE_NET_VOTE_COUNTS_EN
    logic [15:0] out_counts;
`endif

    int checks = 0;
    int errors = 0;

    gate_net_vote_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .frame_len (frame_len),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_tie   (out_tie)
`ifdef GATE_NET_VOTE_COUNTS_EN
        ,
        .out_counts(out_counts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; one call spans exactly one rising edge.
    task automatic put(input logic [1:0] b);
        in_valid = 1'b1;
        in_bits  = b;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_bits  = 2'b00;
    endtask

    task automatic do_handshake();
        idle();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_bits = 2'b00; frame_len = 8'd0;
        flush = 1'b0; out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_class !== 1'b0) begin errors++; $display("FAIL reset_out_class got %b exp 0", out_class); end
        checks++; if (out_tie !== 1'b0) begin errors++; $display("FAIL reset_out_tie got %b exp 0", out_tie); end
`ifdef GATE_NET_VOTE_COUNTS_EN
        checks++; if (out_counts !== 16'h0000) begin errors++; $display("FAIL reset_counts got %h exp 0000", out_counts); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_basic();
        frame_len = 8'd4;
        put(2'b01); put(2'b01); put(2'b10);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", out_valid); end
        put(2'b11);
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
        checks++; if (out_class !== 1'b0) begin errors++; $display("FAIL basic_class got %b exp 0", out_class); end
        checks++; if (out_tie !== 1'b0) begin errors++; $display("FAIL basic_tie got %b exp 0", out_tie); end
`ifdef GATE_NET_VOTE_COUNTS_EN
        checks++; if (out_counts !== 16'h0203) begin errors++; $display("FAIL basic_counts got %h exp 0203", out_counts); end
`endif
        do_handshake();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_post_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_post_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_tie();
        frame_len = 8'd2;
        put(2'b10); put(2'b01);
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tie_valid got %b exp 1", out_valid); end
        checks++; if (out_class !== 1'b0) begin errors++; $display("FAIL tie_class got %b exp 0", out_class); end
        checks++; if (out_tie !== 1'b1) begin errors++; $display("FAIL tie_tie got %b exp 1", out_tie); end
`ifdef GATE_NET_VOTE_COUNTS_EN
        checks++; if (out_counts !== 16'h0101) begin errors++; $display("FAIL tie_counts got %h exp 0101", out_counts); end
`endif
        do_handshake();
    endtask

    task automatic test_stall();
        frame_len = 8'd3;
        put(2'b10); put(2'b10); put(2'b01);
        // counts c0=1 c1=2 -> class 1, no tie
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_bits = 2'b11; flush = k[0];
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %b exp 0", k, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", k, out_valid); end
            checks++; if (out_class !== 1'b1) begin errors++; $display("FAIL stall_class[%0d] got %b exp 1", k, out_class); end
            checks++; if (out_tie !== 1'b0) begin errors++; $display("FAIL stall_tie[%0d] got %b exp 0", k, out_tie); end
            @(negedge clk);
        end
        flush = 1'b0;
        idle();
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_hs_ready got %b exp 0", in_ready); end
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_after_ready got %b exp 1", in_ready); end
        // Stale counts would give c0=2 c1=2 -> tie.
        frame_len = 8'd1;
        put(2'b01);
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_next_valid got %b exp 1", out_valid); end
        checks++; if (out_class !== 1'b0) begin errors++; $display("FAIL stall_next_class got %b exp 0", out_class); end
        checks++; if (out_tie !== 1'b0) begin errors++; $display("FAIL stall_next_tie got %b exp 0", out_tie); end
        do_handshake();
    endtask

    task automatic test_saturate();
        frame_len = 8'd255;
        for (int k = 0; k < 255; k++) begin
            if (k == 254) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_early_valid got %b exp 0", out_valid); end
            end
            put(2'b11);
        end
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_valid got %b exp 1", out_valid); end
        checks++; if (out_class !== 1'b0) begin errors++; $display("FAIL sat_class got %b exp 0", out_class); end
        checks++; if (out_tie !== 1'b1) begin errors++; $display("FAIL sat_tie got %b exp 1", out_tie); end
`ifdef GATE_NET_VOTE_COUNTS_EN
        checks++; if (out_counts !== 16'hffff) begin errors++; $display("FAIL sat_counts got %h exp ffff", out_counts); end
`endif
        do_handshake();
    endtask

    task automatic test_flush();
        frame_len = 8'd4;
        put(2'b01); put(2'b01);
        in_valid = 1'b1; in_bits = 2'b11; flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
        @(negedge clk);
        flush = 1'b0;
        put(2'b10); put(2'b10); put(2'b01);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_early_valid got %b exp 0", out_valid); end
        put(2'b10);
        idle();
        // Clean frame: c0=1 c1=3.
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_valid got %b exp 1", out_valid); end
        checks++; if (out_class !== 1'b1) begin errors++; $display("FAIL flush_class got %b exp 1", out_class); end
        checks++; if (out_tie !== 1'b0) begin errors++; $display("FAIL flush_tie got %b exp 0", out_tie); end
`ifdef GATE_NET_VOTE_COUNTS_EN
        checks++; if (out_counts !== 16'h0301) begin errors++; $display("FAIL flush_counts got %h exp 0301", out_counts); end
`endif
        do_handshake();
        frame_len = 8'd0;
        put(2'b10);
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL len0_valid got %b exp 1", out_valid); end
        checks++; if (out_class !== 1'b1) begin errors++; $display("FAIL len0_class got %b exp 1", out_class); end
        do_handshake();
    endtask

    task automatic test_reset_mid();
        frame_len = 8'd4;
        put(2'b01); put(2'b01);
        idle();
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b exp 1", in_ready); end
        // Stale c0=2 would outvote this single class-1 vote.
        frame_len = 8'd1;
        put(2'b10);
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_next_valid got %b exp 1", out_valid); end
        checks++; if (out_class !== 1'b1) begin errors++; $display("FAIL rmid_next_class got %b exp 1", out_class); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rdone_valid got %b exp 0", out_valid); end
        checks++; if (out_class !== 1'b0) begin errors++; $display("FAIL rdone_class got %b exp 0", out_class); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rdone_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rdone_after_valid got %b exp 0", out_valid); end
`ifdef GATE_NET_VOTE_COUNTS_EN
        checks++; if (out_counts !== 16'h0000) begin errors++; $display("FAIL rdone_counts got %h exp 0000", out_counts); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_stall();
        test_saturate();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_net_vote_accum.md
GATE_NET_VOTE_ACCUM -- requirements
Module: gate_net_vote_accum

Interface
REQ-001 Parameter: NUM_CLASSES, default 2, width of the class vector from the gate-network classifier.
REQ-002 Parameter: CNT_W, default 8, width of each per-class vote counter and of frame_len.
REQ-003 Derived: CLS_W = max(1, clog2(NUM_CLASSES)).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  classifier out_bits sample present.
REQ-008 in_ready  out  1  block accepts the sample this cycle.
REQ-009 in_bits  in  NUM_CLASSES  multi-hot class votes (classifier out_bits).
REQ-010 frame_len  in  CNT_W  samples per frame.
REQ-011 flush  in  1  synchronous discard of the partial frame.
REQ-012 out_valid  out  1  frame decision available.
REQ-013 out_ready  in  1  consumer accepts the decision.
REQ-014 out_class  out  CLS_W  argmax class index.
REQ-015 out_tie  out  1  two or more classes share the maximum count.

Function
REQ-016 States: ACCUM, DONE; the block SHALL reset into ACCUM.
REQ-017 in_ready SHALL equal (state==ACCUM) & ~flush.
REQ-018 A sample is accepted when in_valid & in_ready; for each bit i set, count[i] SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-019 frame_len SHALL be latched on the first accepted sample of each frame; a latched value of 0 SHALL be treated as 1.
REQ-020 When the accepted sample brings the sample count to the latched length, the block SHALL enter DONE next cycle with out_valid=1 (one-cycle latency from the last accept).
REQ-021 out_class SHALL be the lowest index holding the maximum count; an all-zero frame SHALL give out_class=0, out_tie=1 when NUM_CLASSES>1.
REQ-022 out_valid, out_class, and out_tie SHALL remain stable in DONE until out_valid & out_ready.
REQ-023 On the output handshake, the block SHALL clear all counters and the sample count and return to ACCUM; in_ready SHALL rise the following cycle.
REQ-024 flush in ACCUM SHALL clear counters and the sample count; a sample presented in the same cycle SHALL be dropped (in_ready=0).
REQ-025 flush in DONE SHALL be ignored; the pending decision SHALL still be delivered.
REQ-026 Sample-count wrap SHALL be impossible: the count never exceeds the latched frame_len.

Reset
REQ-027 On rst_n low, the block SHALL set state=ACCUM, clear all counters, and drive out_valid=0, out_class=0, out_tie=0; in_ready SHALL be 1 after release.
REQ-028 Reset mid-frame or in DONE SHALL discard all partial or pending results without an output handshake.

Configuration
REQ-029 Macro GATE_NET_VOTE_COUNTS_EN: when defined, the block SHALL add output out_counts (NUM_CLASSES*CNT_W, class 0 in the LSBs) holding the final frame counts, valid and stable with out_valid and zero after reset.
REQ-030 Without GATE_NET_VOTE_COUNTS_EN, the out_counts port and any extra storage SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package gate_net_pkg SHALL hold NUM_CLASSES, CNT_W, CLS_W defaults and the state enum (ACCUM, DONE).
REQ-032 The combinational argmax/tie logic SHALL be a sub-module gate_net_argmax, instantiated once.

Verification
REQ-033 frame_len=4, inputs 01,01,10,11 -> out_valid one cycle after 4th accept, out_class=0 (counts 3,2), out_tie=0.
REQ-034 frame_len=2, inputs 10,01 -> out_class=0, out_tie=1; with the macro, out_counts=0x0101.
REQ-035 frame_len=3, out_ready held low 5 cycles in DONE while in_valid=1 -> in_ready=0, outputs stable, flush ignored; after handshake, next frame starts with zero counts.
REQ-036 CNT_W=8, frame_len=255, all inputs 11 -> counts saturate at 255, out_tie=1, no wrap.
REQ-037 Two samples accepted then flush concurrent with in_valid -> sample dropped, counts zero; next 4-sample frame decided correctly; frame_len=0 -> decision after 1 sample.
REQ-038 rst_n asserted mid-frame and in DONE -> out_valid falls immediately, counters zero, in_ready=1 after release.
